// File: rtl/dp_ram_sweep.sv
// dp_ram_sweep: single-clock true dual-port RAM with a selectable
// read-during-write mode, an optional output register, a hardware clear
// sweep that writes CLEAR_VAL to every word, and same-address write
// collision detection. Port A wins a write collision.
module dp_ram_sweep #(
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 4,
  parameter int                RDW_MODE  = 0,
  parameter int                OUT_REG   = 0,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clka,
  input  logic              rst,
  input  logic              ena,
  input  logic              wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  output logic [DATA_W-1:0] douta,
  input  logic              enb,
  input  logic              web,
  input  logic [ADDR_W-1:0] addrb,
  input  logic [DATA_W-1:0] dinb,
  output logic [DATA_W-1:0] doutb,
  input  logic              clr_req,
  output logic              busy,
  output logic              collision
);

  localparam int                DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              vld_a_p0, vld_b_p0;
  logic              wr_a, wr_b_req, wr_b, col;
  logic [DATA_W-1:0] rd_a, rd_b;
  logic [DATA_W-1:0] dout_a_p0, dout_b_p0;
  logic              col_p0;

  // Port accesses only count while the sweep is idle; B's write is dropped
  // when both ports write the same word.
  assign vld_a_p0 = (state == S_IDLE) && ena;
  assign vld_b_p0 = (state == S_IDLE) && enb;
  assign wr_a     = vld_a_p0 && wea;
  assign wr_b_req = vld_b_p0 && web;
  assign col      = wr_a && wr_b_req && (addra == addrb);
  assign wr_b     = wr_b_req && !col;
  assign busy     = (state == S_CLEAR);

  // Sweep state and counter; reset restarts the sweep from word 0.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      state <= S_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state: walk every word once, or restart the sweep on clr_req.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == S_CLEAR) begin
      cnt_nxt = cnt + ADDR_W'(1);
      if (cnt == LAST) begin
        state_nxt = S_IDLE;
      end
    end else if (clr_req) begin
      state_nxt = S_CLEAR;
      cnt_nxt   = '0;
    end
  end

  // Read data: old word in read-first mode; in write-first mode a port sees
  // its own write data, otherwise the word as left by this cycle's writes.
  always_comb begin
    rd_a = mem[addra];
    rd_b = mem[addrb];
    if (RDW_MODE != 0) begin
      if (wr_a) begin
        rd_a = dina;
      end else if (wr_b && (addrb == addra)) begin
        rd_a = dinb;
      end
      if (wr_b_req) begin
        rd_b = dinb;
      end else if (wr_a && (addra == addrb)) begin
        rd_b = dina;
      end
    end
  end

  // Storage: the sweep owns the array while busy; contents are never reset.
  always_ff @(posedge clka) begin
    if (state == S_CLEAR) begin
      mem[cnt] <= CLEAR_VAL;
    end else begin
      if (wr_a) begin
        mem[addra] <= dina;
      end
      if (wr_b) begin
        mem[addrb] <= dinb;
      end
    end
  end

  // Stage p0: capture read data on enabled cycles, hold otherwise.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      dout_a_p0 <= '0;
      dout_b_p0 <= '0;
      col_p0    <= 1'b0;
    end else begin
      if (vld_a_p0) begin
        dout_a_p0 <= rd_a;
      end
      if (vld_b_p0) begin
        dout_b_p0 <= rd_b;
      end
      col_p0 <= col;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_W-1:0] dout_a_p1, dout_b_p1;
      logic              col_p1;

      // Stage p1: extra output register, collision delayed to stay aligned.
      always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
          dout_a_p1 <= '0;
          dout_b_p1 <= '0;
          col_p1    <= 1'b0;
        end else begin
          dout_a_p1 <= dout_a_p0;
          dout_b_p1 <= dout_b_p0;
          col_p1    <= col_p0;
        end
      end

      assign douta     = dout_a_p1;
      assign doutb     = dout_b_p1;
      assign collision = col_p1;
    end else begin : g_no_out_reg
      assign douta     = dout_a_p0;
      assign doutb     = dout_b_p0;
      assign collision = col_p0;
    end
  endgenerate

endmodule

// File: tb/tb_dp_ram_sweep.sv
// Bench for dp_ram_sweep: two instances (read-first/no output register and
// write-first/output register) share stimulus and are compared against a
// behavioural memory model every cycle, plus directed scenario checks.
module tb_dp_ram_sweep;

  logic       clka = 1'b0;
  logic       rst = 1'b0;
  logic       ena = 1'b0, wea = 1'b0, enb = 1'b0, web = 1'b0, clr_req = 1'b0;
  logic [3:0] addra = '0, addrb = '0;
  logic [7:0] dina = '0, dinb = '0;

  logic [7:0] douta0, doutb0, douta1, doutb1;
  logic       busy0, busy1, col0, col1;

  int tests_run = 0;
  int fails = 0;

  always #5 clka = ~clka;

  dp_ram_sweep #(.DATA_W(8), .ADDR_W(4), .RDW_MODE(0), .OUT_REG(0), .CLEAR_VAL(8'h00)) u_dut0 (
    .clka(clka), .rst(rst),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta0),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb0),
    .clr_req(clr_req), .busy(busy0), .collision(col0)
  );

  dp_ram_sweep #(.DATA_W(8), .ADDR_W(4), .RDW_MODE(1), .OUT_REG(1), .CLEAR_VAL(8'h00)) u_dut1 (
    .clka(clka), .rst(rst),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta1),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb1),
    .clr_req(clr_req), .busy(busy1), .collision(col1)
  );

  // Reference model state
  logic [7:0] ref_mem [16];
  int         rem;                 // sweep edges still to go (0 = idle)
  logic [7:0] e0a, e0b;            // expected outputs, read-first instance
  logic [7:0] s1a, s1b, e1a, e1b;  // write-first instance: first/second cycle
  logic       c0, c1s, c1;

  wire [35:0] obs = {douta0, doutb0, douta1, doutb1, busy0, busy1, col0, col1};

  function automatic logic [35:0] exp_vec();
    return {e0a, e0b, e1a, e1b, (rem > 0), (rem > 0), c0, c1};
  endfunction

  task automatic model_reset();
    rem = 16;
    e0a = '0; e0b = '0; s1a = '0; s1b = '0; e1a = '0; e1b = '0;
    c0 = 1'b0; c1s = 1'b0; c1 = 1'b0;
  endtask

  // Advance model by one clock using current inputs, then advance the DUTs.
  task automatic step();
    logic [7:0] old [16];
    logic wa, wbr, wb, cl;
    old = ref_mem;
    cl  = 1'b0;
    e1a = s1a; e1b = s1b; c1 = c1s;
    if (rem == 0) begin
      wa  = ena && wea;
      wbr = enb && web;
      cl  = wa && wbr && (addra == addrb);
      wb  = wbr && !cl;
      if (wb) ref_mem[addrb] = dinb;
      if (wa) ref_mem[addra] = dina;
      if (ena) begin
        e0a = old[addra];
        s1a = ref_mem[addra];
      end
      if (enb) begin
        e0b = old[addrb];
        s1b = web ? dinb : ref_mem[addrb];
      end
      if (clr_req) rem = 16;
    end else begin
      ref_mem[16 - rem] = 8'h00;
      rem = rem - 1;
    end
    c0 = cl; c1s = cl;
    @(posedge clka);
    #1;
  endtask

  task automatic idle_inputs();
    ena = 1'b0; wea = 1'b0; enb = 1'b0; web = 1'b0; clr_req = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    model_reset();
    #1;
    tests_run++;
    if (obs !== exp_vec()) begin
      fails++;
      $display("FAIL reset_values: got %h want %h", obs, exp_vec());
    end
    @(posedge clka);
    @(posedge clka);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      tests_run++;
      if (obs !== exp_vec() || busy0 !== (i < 15)) begin
        fails++;
        $display("FAIL sweep_busy edge %0d: got %h want %h", i + 1, obs, exp_vec());
      end
    end
    for (int i = 0; i < 17; i++) begin
      ena = (i < 16); enb = (i < 16);
      addra = 4'(i); addrb = 4'(15 - i);
      step();
      tests_run++;
      if (obs !== exp_vec() || douta0 !== 8'h00 || doutb1 !== 8'h00) begin
        fails++;
        $display("FAIL cleared_read %0d: got %h want %h", i, obs, exp_vec());
      end
    end
    idle_inputs();
  endtask

  task automatic test_write_read();
    ena = 1'b1; wea = 1'b1; addra = 4'd3; dina = 8'h5A;
    step();
    idle_inputs();
    enb = 1'b1; addrb = 4'd3;
    step();
    tests_run++;
    if (doutb0 !== 8'h5A || obs !== exp_vec()) begin
      fails++;
      $display("FAIL write_then_read lat1: got %h want 5a (vec %h want %h)", doutb0, obs, exp_vec());
    end
    idle_inputs();
    step();
    tests_run++;
    if (doutb1 !== 8'h5A || obs !== exp_vec()) begin
      fails++;
      $display("FAIL write_then_read lat2: got %h want 5a (vec %h want %h)", doutb1, obs, exp_vec());
    end
  endtask

  task automatic test_rdw();
    ena = 1'b1; wea = 1'b1; addra = 4'd7; dina = 8'h22;
    step();
    dina = 8'h11; enb = 1'b1; web = 1'b0; addrb = 4'd7;
    step();
    tests_run++;
    if (doutb0 !== 8'h22 || obs !== exp_vec()) begin
      fails++;
      $display("FAIL rdw_read_first: got %h want 22 (vec %h want %h)", doutb0, obs, exp_vec());
    end
    idle_inputs();
    step();
    tests_run++;
    if (doutb1 !== 8'h11 || douta1 !== 8'h11 || obs !== exp_vec()) begin
      fails++;
      $display("FAIL rdw_write_first: got %h want 11 (vec %h want %h)", doutb1, obs, exp_vec());
    end
  endtask

  task automatic test_collision();
    ena = 1'b1; wea = 1'b1; addra = 4'd9; dina = 8'hAA;
    enb = 1'b1; web = 1'b1; addrb = 4'd9; dinb = 8'hBB;
    step();
    tests_run++;
    if (col0 !== 1'b1 || col1 !== 1'b0 || obs !== exp_vec()) begin
      fails++;
      $display("FAIL collision_pulse_a: got %b%b want 10 (vec %h want %h)", col0, col1, obs, exp_vec());
    end
    idle_inputs();
    step();
    tests_run++;
    if (col0 !== 1'b0 || col1 !== 1'b1 || obs !== exp_vec()) begin
      fails++;
      $display("FAIL collision_pulse_b: got %b%b want 01 (vec %h want %h)", col0, col1, obs, exp_vec());
    end
    ena = 1'b1; enb = 1'b1; addra = 4'd9; addrb = 4'd9;
    step();
    tests_run++;
    if (douta0 !== 8'hAA || doutb0 !== 8'hAA || col1 !== 1'b0 || obs !== exp_vec()) begin
      fails++;
      $display("FAIL collision_winner: got %h/%h want aa/aa (vec %h want %h)", douta0, doutb0, obs, exp_vec());
    end
    idle_inputs();
    step();
    tests_run++;
    if (douta1 !== 8'hAA || doutb1 !== 8'hAA || obs !== exp_vec()) begin
      fails++;
      $display("FAIL collision_winner_reg: got %h/%h want aa/aa", douta1, doutb1);
    end
  endtask

  task automatic test_clear_reset();
    for (int i = 0; i < 16; i++) begin
      ena = 1'b1; wea = 1'b1; addra = 4'(i); dina = 8'hFF;
      step();
    end
    idle_inputs();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    tests_run++;
    if (busy0 !== 1'b1 || busy1 !== 1'b1) begin
      fails++;
      $display("FAIL clr_req_busy: got %b%b want 11", busy0, busy1);
    end
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    model_reset();
    #1;
    tests_run++;
    if (obs !== exp_vec()) begin
      fails++;
      $display("FAIL midsweep_reset: got %h want %h", obs, exp_vec());
    end
    #1;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      tests_run++;
      if (obs !== exp_vec() || busy1 !== (i < 15)) begin
        fails++;
        $display("FAIL resweep_busy edge %0d: got %h want %h", i + 1, obs, exp_vec());
      end
    end
    for (int i = 0; i < 17; i++) begin
      ena = (i < 16); enb = (i < 16);
      addra = 4'(i); addrb = 4'(i);
      step();
      tests_run++;
      if (obs !== exp_vec() || douta0 !== 8'h00 || douta1 !== 8'h00) begin
        fails++;
        $display("FAIL resweep_read %0d: got %h want %h", i, obs, exp_vec());
      end
    end
    idle_inputs();
  endtask

  task automatic test_busy_access();
    logic [7:0] hold0, hold1;
    ena = 1'b1; wea = 1'b1; addra = 4'd2; dina = 8'h3C;
    step();
    idle_inputs();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    hold0 = douta0;
    hold1 = douta1;
    ena = 1'b1; wea = 1'b1; addra = 4'd2; dina = 8'h77;
    for (int i = 0; i < 16; i++) begin
      step();
      tests_run++;
      if (douta0 !== hold0 || douta1 !== hold1 || obs !== exp_vec()) begin
        fails++;
        $display("FAIL busy_hold edge %0d: got %h/%h want %h/%h", i, douta0, douta1, hold0, hold1);
      end
    end
    wea = 1'b0;
    step();
    tests_run++;
    if (douta0 !== 8'h00 || obs !== exp_vec()) begin
      fails++;
      $display("FAIL busy_write_ignored: got %h want 00", douta0);
    end
    idle_inputs();
    step();
    tests_run++;
    if (douta1 !== 8'h00 || obs !== exp_vec()) begin
      fails++;
      $display("FAIL busy_write_ignored_reg: got %h want 00", douta1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      ena = 1'($urandom_range(0, 1));
      wea = 1'($urandom_range(0, 1));
      enb = 1'($urandom_range(0, 1));
      web = 1'($urandom_range(0, 1));
      addra = 4'($urandom_range(0, 15));
      addrb = ($urandom_range(0, 3) == 0) ? addra : 4'($urandom_range(0, 15));
      dina = 8'($urandom);
      dinb = 8'($urandom);
      clr_req = ($urandom_range(0, 59) == 0);
      step();
      tests_run++;
      if (obs !== exp_vec()) begin
        fails++;
        $display("FAIL random cycle %0d: got %h want %h", i, obs, exp_vec());
      end
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    model_reset();
    test_reset();
    test_write_read();
    test_rdw();
    test_collision();
    test_busy_access();
    test_random();
    test_clear_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
